// File: rtl/ex_div_sequencer.sv
// Iterative restoring divider with its IDLE/CALC/DONE sequencer for RV32M DIV/DIVU/REM/REMU.
// Optional result cache: define DIV_RESULT_CACHE_EN.
module ex_div_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       div_type,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall_req
);
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         type_q, type_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept, is_signed, sa, sb, div_zero, ovf, hit;
  logic [WIDTH-1:0]   abs_a, abs_b, step_q, step_r, fix_q, fix_r, hit_res;
  logic [WIDTH:0]     tmp, diff;

  assign accept    = (state_q != CALC) & start & ~flush;
  assign is_signed = ~div_type[0];
  assign sa        = is_signed & dividend[WIDTH-1];
  assign sb        = is_signed & divisor[WIDTH-1];
  assign abs_a     = sa ? (~dividend + 1'b1) : dividend;
  assign abs_b     = sb ? (~divisor + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed & (dividend == MIN_NEG) & (divisor == '1);

  // Restoring steps: tmp is the WIDTH+1-bit partial remainder after shifting in the next dividend bit.
  always_comb begin
    step_r = rem_q;
    step_q = quo_q;
    tmp    = '0;
    diff   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      tmp  = {step_r, step_q[WIDTH-1]};
      diff = tmp - {1'b0, dvsr_q};
      if (tmp >= {1'b0, dvsr_q}) begin
        step_r = diff[WIDTH-1:0];
        step_q = {step_q[WIDTH-2:0], 1'b1};
      end else begin
        step_r = tmp[WIDTH-1:0];
        step_q = {step_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign fix_q = negq_q ? (~step_q + 1'b1) : step_q;
  assign fix_r = negr_q ? (~step_r + 1'b1) : step_r;

`ifdef DIV_RESULT_CACHE_EN
  logic [WIDTH-1:0] opa_q, opb_q, ca_q, cb_q, cquo_q, crem_q;
  logic             sgn_q, cs_q, cvld_q, cache_we;

  // Only an operation that actually completes its CALC phase refreshes the cache.
  assign cache_we = (state_q == CALC) & (cnt_q == '0) & ~flush;
  assign hit      = cvld_q & (dividend == ca_q) & (divisor == cb_q) & (is_signed == cs_q);
  assign hit_res  = div_type[1] ? crem_q : cquo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      sgn_q  <= 1'b0;
      ca_q   <= '0;
      cb_q   <= '0;
      cs_q   <= 1'b0;
      cquo_q <= '0;
      crem_q <= '0;
      cvld_q <= 1'b0;
    end else begin
      if (accept) begin
        opa_q <= dividend;
        opb_q <= divisor;
        sgn_q <= is_signed;
      end
      if (cache_we) begin
        ca_q   <= opa_q;
        cb_q   <= opb_q;
        cs_q   <= sgn_q;
        cquo_q <= fix_q;
        crem_q <= fix_r;
        cvld_q <= 1'b1;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      rem_d = step_r;
      quo_d = step_q;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d  = DONE;
        result_d = type_q[1] ? fix_r : fix_q;
      end
    end else begin
      state_d = IDLE;
      if (accept) begin
        type_d = div_type;
        negq_d = sa ^ sb;
        negr_d = sa;
        dvsr_d = abs_b;
        quo_d  = abs_a;
        rem_d  = '0;
        cnt_d  = CNT_W'(N - 1);
        if (div_zero) begin
          state_d  = DONE;
          result_d = div_type[1] ? dividend : '1;
        end else if (ovf) begin
          state_d  = DONE;
          result_d = div_type[1] ? '0 : dividend;
        end else if (hit) begin
          state_d  = DONE;
          result_d = hit_res;
        end else begin
          state_d = CALC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      type_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dvsr_q   <= dvsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == CALC) | (state_q == DONE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign stall_req = ((state_q == IDLE) & start & ~flush) | (state_q == CALC);

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed self-checking bench for ex_div_sequencer (default WIDTH=32, BITS_PER_CYCLE=1).
module tb_ex_div_sequencer;
  logic        clk, rst_n, flush, start;
  logic [1:0]  div_type;
  logic [31:0] dividend, divisor;
  logic        busy, done, stall_req;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 33;
`endif

  ex_div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
    .div_type(div_type), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op (called just after a rising edge), wait for done, check latency/result/stall.
  task automatic do_op(input string tag, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic stall_ok;
    logic was_idle;
    div_type = t; dividend = a; divisor = b; start = 1'b1;
    was_idle = ~busy;
    #1;
    if (was_idle) check_eq({tag, "_stall_start"}, {31'd0, stall_req}, 32'd1);
    lat = 0;
    stall_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 100) begin
      if (!stall_req || !busy) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
    check_eq({tag, "_stall_calc"}, {31'd0, stall_ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; flush = 1'b0; start = 1'b0;
    div_type = 2'b00; dividend = '0; divisor = '0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_req}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("uu_div_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    idle(1);
    check_eq("result_hold", result, 32'd14);
    check_eq("idle_done", {31'd0, done}, 32'd0);

    do_op("ss_div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("ss_rem_m7_2_b2b", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, HIT_LAT);
    idle(2);

    do_op("uu_div_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("ss_rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1);
    do_op("ss_div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("ss_rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    idle(2);

    // Flush on the 10th CALC cycle.
    div_type = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(9);
    check_eq("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    check_eq("flush_done", {31'd0, done}, 32'd0);
    check_eq("flush_stall", {31'd0, stall_req}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check_eq("flush_no_done", ndone, 0);
    do_op("uu_rem_17_5", 2'b11, 32'd17, 32'd5, 32'd2, 33);
    idle(2);

    // Asynchronous reset in the middle of CALC.
    div_type = 2'b01; dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(5);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_stall", {31'd0, stall_req}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    check_eq("arst_result", result, 32'd0);
    #10;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_eq("arst_no_done", ndone, 0);

    do_op("ss_div_1000_3", 2'b00, 32'd1000, 32'd3, 32'd333, 33);
    idle(1);
    do_op("ss_rem_1000_3", 2'b10, 32'd1000, 32'd3, 32'd1, HIT_LAT);
    idle(1);
    do_op("uu_div_1000_3", 2'b01, 32'd1000, 32'd3, 32'd333, 33);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
